// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier.
// One adder pass per clock through a selectable 32-bit adder.
module cla32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        CarryIn,
  output logic [31:0] Result,
  output logic        CarryOut
);
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [8:0]  bc;
  logic [7:0]  gg;
  logic [7:0]  pg;

  assign g = A & B;
  assign p = A ^ B;

  // 4-bit lookahead groups, group carries chained by group g/p
  always_comb begin
    int j;
    bc = '0;
    c  = '0;
    gg = '0;
    pg = '0;
    bc[0] = CarryIn;
    for (int k = 0; k < 8; k++) begin
      j = 4 * k;
      c[j]   = bc[k];
      c[j+1] = g[j] | (p[j] & bc[k]);
      c[j+2] = g[j+1] | (p[j+1] & g[j])
             | (p[j+1] & p[j] & bc[k]);
      c[j+3] = g[j+2] | (p[j+2] & g[j+1])
             | (p[j+2] & p[j+1] & g[j])
             | (p[j+2] & p[j+1] & p[j] & bc[k]);
      gg[k]  = g[j+3] | (p[j+3] & g[j+2])
             | (p[j+3] & p[j+2] & g[j+1])
             | (p[j+3] & p[j+2] & p[j+1] & g[j]);
      pg[k]  = &p[j+:4];
      bc[k+1] = gg[k] | (pg[k] & bc[k]);
    end
  end

  assign Result   = p ^ c;
  assign CarryOut = bc[8];
endmodule

module cbya32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        CarryIn,
  output logic [31:0] Result,
  output logic        CarryOut
);
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [8:0]  bc;

  assign g = A & B;
  assign p = A ^ B;

  // ripple inside 4-bit blocks; a fully propagating block bypasses
  always_comb begin
    int   j;
    logic r;
    bc = '0;
    c  = '0;
    bc[0] = CarryIn;
    for (int k = 0; k < 8; k++) begin
      j = 4 * k;
      r = bc[k];
      for (int i = 0; i < 4; i++) begin
        c[j+i] = r;
        r = g[j+i] | (p[j+i] & r);
      end
      bc[k+1] = (&p[j+:4]) ? bc[k] : r;
    end
  end

  assign Result   = p ^ c;
  assign CarryOut = bc[8];
endmodule

module seq_shift_add_mult #(
  parameter int ADDER_SEL = 0,
  parameter int WIDTH     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Product,
  output logic               HiNonZero
);
  if (WIDTH != 32) begin : g_width_err
    $error("seq_shift_add_mult: WIDTH must be 32");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] mcand_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [4:0]  count_q;
  logic [63:0] prod_q;
  logic        hnz_q;
  logic [31:0] addb;
  logic [31:0] sum;
  logic        cout;
  logic [63:0] nxt;

  assign addb = lo_q[0] ? mcand_q : 32'h0;

  if (ADDER_SEL == 0) begin : g_cla
    cla32bit u_add (
      .A        (hi_q),
      .B        (addb),
      .CarryIn  (1'b0),
      .Result   (sum),
      .CarryOut (cout)
    );
  end else begin : g_cbya
    cbya32bit u_add (
      .A        (hi_q),
      .B        (addb),
      .CarryIn  (1'b0),
      .Result   (sum),
      .CarryOut (cout)
    );
  end

  // carry re-enters at the top as the pair shifts right
  assign nxt = {cout, sum, lo_q[31:1]};

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (count_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
      prod_q  <= '0;
      hnz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        mcand_q <= A;
        lo_q    <= B;
        hi_q    <= '0;
        count_q <= '0;
      end
      if (state_q == RUN) begin
        {hi_q, lo_q} <= nxt;
        count_q      <= count_q + 5'd1;
        if (count_q == 5'd31) begin
          prod_q <= nxt;
          hnz_q  <= |nxt[63:32];
        end
      end
    end
  end

  assign Product   = prod_q;
  assign HiNonZero = hnz_q;
endmodule
